// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for a 4-digit seven-segment display with frame-synchronous value updates.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seven_seg_scan_ctrl #(
  parameter int unsigned PRESCALE   = 50000,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        upd_req,
  output logic        upd_ack,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic [1:0]  sel,
  output logic        frame_tick
);

  localparam logic [PRESCALE_W-1:0] PCNT_MAX = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] pcnt;
  logic [1:0]            sel_q;
  logic [15:0]           disp_q;
  logic                  upd_ack_q;
  logic                  frame_tick_q;
  logic                  tick;
  logic                  boundary;
  logic [3:0]            an_dec;

  assign tick     = (pcnt == PCNT_MAX);
  assign boundary = tick && (sel_q == 2'd3);

  // Prescaler, digit index and frame-boundary capture of the display value.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt         <= '0;
      sel_q        <= 2'd0;
      disp_q       <= 16'h0000;
      upd_ack_q    <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      pcnt         <= tick ? '0 : pcnt + PRESCALE_W'(1);
      frame_tick_q <= boundary;
      upd_ack_q    <= boundary && upd_req;
      if (tick) begin
        sel_q <= sel_q + 2'd1;
      end
      if (boundary && upd_req) begin
        disp_q <= data_in;
      end
    end
  end

  // Digit mux and one-hot active-low anode decode.
  always_comb begin
    digit  = 4'h0;
    an_dec = 4'b1111;
    case (sel_q)
      2'd0: begin digit = disp_q[15:12]; an_dec = 4'b0111; end
      2'd1: begin digit = disp_q[11:8];  an_dec = 4'b1011; end
      2'd2: begin digit = disp_q[7:4];   an_dec = 4'b1101; end
      default: begin digit = disp_q[3:0]; an_dec = 4'b1110; end
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lead_zero;

  // Blank a digit when it and every more-significant digit are zero; the last digit always shows.
  always_comb begin
    lead_zero = 1'b0;
    case (sel_q)
      2'd0:    lead_zero = (disp_q[15:12] == 4'h0);
      2'd1:    lead_zero = (disp_q[15:8] == 8'h00);
      2'd2:    lead_zero = (disp_q[15:4] == 12'h000);
      default: lead_zero = 1'b0;
    endcase
  end

  assign an = lead_zero ? 4'b1111 : an_dec;
`else
  assign an = an_dec;
`endif

  assign sel        = sel_q;
  assign upd_ack    = upd_ack_q;
  assign frame_tick = frame_tick_q;

endmodule
